// File: rtl/adc_cal_sequencer.sv
// ADC reset/calibration sequencer for the two LiTE-DTU ADCs (bit0 g01, bit1 g10).
// Holds the DTU flushed while the sequence runs and flags calibration-busy timeouts.
module adc_cal_sequencer #(
  parameter int RST_PULSE_LEN = 8,
  parameter int CAL_PULSE_LEN = 4,
  parameter int BUSY_WAIT     = 16,
  parameter int CAL_TIMEOUT   = 4096,
  parameter int CNT_W         = 16
) (
  input  logic       clock,
  input  logic       rst,
  input  logic       cal_req,
  input  logic       abort,
  input  logic [1:0] adc_sel,
  input  logic       skip_adc_rst,
  input  logic [1:0] adc_cal_busy,
  output logic [1:0] adc_rst_b,
  output logic [1:0] adc_cal,
  output logic       dtu_flush_b,
  output logic       busy,
  output logic       cal_done,
  output logic [1:0] cal_error,
  output logic [2:0] state
);

  // state        | meaning
  // IDLE         | waiting for cal_req with a non-empty adc_sel
  // ADC_RST      | selected ADC resets held low
  // RST_WAIT     | resets released, settling
  // CAL_PULSE    | calibration start held high on selected ADCs
  // WAIT_BUSY_HI | waiting for a selected ADC to report busy
  // WAIT_BUSY_LO | waiting for all selected ADCs to drop busy
  // DONE         | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE         = 3'd0,
    S_ADC_RST      = 3'd1,
    S_RST_WAIT     = 3'd2,
    S_CAL_PULSE    = 3'd3,
    S_WAIT_BUSY_HI = 3'd4,
    S_WAIT_BUSY_LO = 3'd5,
    S_DONE         = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] RST_LOAD  = CNT_W'(RST_PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] CAL_LOAD  = CNT_W'(CAL_PULSE_LEN - 1);
  localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'(BUSY_WAIT - 1);
  localparam logic [CNT_W-1:0] TO_LOAD   = CNT_W'(CAL_TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       err_d;
  logic             busy_hit;
  logic             cnt_zero;

  logic [1:0] adc_rst_b_d, adc_cal_d;
  logic       dtu_flush_b_d, busy_d, cal_done_d;

  assign state    = state_q;
  assign busy_hit = |(adc_cal_busy & sel_q);
  assign cnt_zero = (cnt_q == '0);

  // Outputs are computed from the next state so the registered copies line up
  // with the state register.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sel_q       <= 2'b00;
      cal_error   <= 2'b00;
      adc_rst_b   <= 2'b11;
      adc_cal     <= 2'b00;
      dtu_flush_b <= 1'b1;
      busy        <= 1'b0;
      cal_done    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      cal_error   <= err_d;
      adc_rst_b   <= adc_rst_b_d;
      adc_cal     <= adc_cal_d;
      dtu_flush_b <= dtu_flush_b_d;
      busy        <= busy_d;
      cal_done    <= cal_done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    err_d   = cal_error;
    cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;
    case (state_q)
      S_IDLE: begin
        if (cal_req && (adc_sel != 2'b00)) begin
          sel_d = adc_sel;
          err_d = 2'b00;
          if (skip_adc_rst) begin
            state_d = S_CAL_PULSE;
            cnt_d   = CAL_LOAD;
          end else begin
            state_d = S_ADC_RST;
            cnt_d   = RST_LOAD;
          end
        end
      end
      S_ADC_RST: begin
        if (cnt_zero) begin
          state_d = S_RST_WAIT;
          cnt_d   = RST_LOAD;
        end
      end
      S_RST_WAIT: begin
        if (cnt_zero) begin
          state_d = S_CAL_PULSE;
          cnt_d   = CAL_LOAD;
        end
      end
      S_CAL_PULSE: begin
        if (cnt_zero) begin
          state_d = S_WAIT_BUSY_HI;
          cnt_d   = BUSY_LOAD;
        end
      end
      S_WAIT_BUSY_HI: begin
        // A busy seen on the last counted cycle still counts as a response.
        if (busy_hit) begin
          state_d = S_WAIT_BUSY_LO;
          cnt_d   = TO_LOAD;
        end else if (cnt_zero) begin
          state_d  = S_DONE;
          err_d[0] = 1'b1;
        end
      end
      S_WAIT_BUSY_LO: begin
        if (!busy_hit) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else if (cnt_zero) begin
          state_d  = S_DONE;
          err_d[1] = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      sel_d   = 2'b00;
      err_d   = cal_error;
    end
  end

  always_comb begin
    adc_rst_b_d   = (state_d == S_ADC_RST) ? ~sel_d : 2'b11;
    adc_cal_d     = (state_d == S_CAL_PULSE) ? sel_d : 2'b00;
    dtu_flush_b_d = (state_d == S_IDLE);
    busy_d        = (state_d != S_IDLE);
    cal_done_d    = (state_d == S_DONE);
  end

endmodule

// File: tb/tb_adc_cal_sequencer.sv
// Directed bench for adc_cal_sequencer; a second instance runs with a short
// calibration timeout for the stuck-busy case.
module tb_adc_cal_sequencer;

  logic       clock = 1'b0;
  logic       rst = 1'b1;
  logic       cal_req = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] adc_sel = 2'b00;
  logic       skip_adc_rst = 1'b0;
  logic [1:0] adc_cal_busy = 2'b00;

  logic [1:0] adc_rst_b, adc_cal, cal_error;
  logic       dtu_flush_b, busy, cal_done;
  logic [2:0] state;

  logic [1:0] adc_rst_b_to, adc_cal_to, cal_error_to;
  logic       dtu_flush_b_to, busy_to, cal_done_to;
  logic [2:0] state_to;

  int checks = 0;
  int errors = 0;

  adc_cal_sequencer dut (
    .clock(clock), .rst(rst), .cal_req(cal_req), .abort(abort), .adc_sel(adc_sel),
    .skip_adc_rst(skip_adc_rst), .adc_cal_busy(adc_cal_busy), .adc_rst_b(adc_rst_b),
    .adc_cal(adc_cal), .dtu_flush_b(dtu_flush_b), .busy(busy), .cal_done(cal_done),
    .cal_error(cal_error), .state(state)
  );

  adc_cal_sequencer #(.CAL_TIMEOUT(64)) dut_to (
    .clock(clock), .rst(rst), .cal_req(cal_req), .abort(abort), .adc_sel(adc_sel),
    .skip_adc_rst(skip_adc_rst), .adc_cal_busy(adc_cal_busy), .adc_rst_b(adc_rst_b_to),
    .adc_cal(adc_cal_to), .dtu_flush_b(dtu_flush_b_to), .busy(busy_to), .cal_done(cal_done_to),
    .cal_error(cal_error_to), .state(state_to)
  );

  always #5 clock = ~clock;

  wire [11:0] obs    = {state, adc_rst_b, adc_cal, dtu_flush_b, busy, cal_done, cal_error};
  wire [11:0] obs_to = {state_to, adc_rst_b_to, adc_cal_to, dtu_flush_b_to, busy_to,
                        cal_done_to, cal_error_to};

  // Expected {state, adc_rst_b, adc_cal, dtu_flush_b, busy, cal_done, cal_error}
  function automatic logic [11:0] exp_vec(input logic [2:0] st, input logic [1:0] rstb,
                                          input logic [1:0] cal, input logic [1:0] err);
    return {st, rstb, cal, st == 3'd0, st != 3'd0, st == 3'd6, err};
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    cal_req = 1'b0;
    abort = 1'b0;
    skip_adc_rst = 1'b0;
    adc_sel = 2'b00;
    adc_cal_busy = 2'b00;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    adc_sel = 2'b11;
    cal_req = 1'b1;
    tick();
    tick();
    checks++;
    if (obs !== exp_vec(3'd0, 2'b11, 2'b00, 2'b00)) begin
      errors++;
      $display("FAIL reset: got %b expected %b", obs, exp_vec(3'd0, 2'b11, 2'b00, 2'b00));
    end
    checks++;
    if (obs_to !== exp_vec(3'd0, 2'b11, 2'b00, 2'b00)) begin
      errors++;
      $display("FAIL reset_to: got %b expected %b", obs_to, exp_vec(3'd0, 2'b11, 2'b00, 2'b00));
    end
    cal_req = 1'b0;
    adc_sel = 2'b00;
    rst = 1'b0;
  endtask

  task automatic test_nominal;
    logic [2:0] st;
    logic [11:0] ev;
    do_reset();
    adc_sel = 2'b11;
    cal_req = 1'b1;
    tick();
    cal_req = 1'b0;
    for (int cyc = 1; cyc <= 102; cyc++) begin
      adc_cal_busy = (cyc >= 23 && cyc < 100) ? 2'b11 : 2'b00;
      st = (cyc <= 8) ? 3'd1 : (cyc <= 16) ? 3'd2 : (cyc <= 20) ? 3'd3 :
           (cyc <= 23) ? 3'd4 : (cyc <= 100) ? 3'd5 : (cyc == 101) ? 3'd6 : 3'd0;
      ev = exp_vec(st, (st == 3'd1) ? 2'b00 : 2'b11, (st == 3'd3) ? 2'b11 : 2'b00, 2'b00);
      checks++;
      if (obs !== ev) begin
        errors++;
        $display("FAIL nominal cycle %0d: got %b expected %b", cyc, obs, ev);
      end
      tick();
    end
  endtask

  task automatic test_skip_g10;
    logic [2:0] st;
    logic [11:0] ev;
    do_reset();
    adc_sel = 2'b10;
    skip_adc_rst = 1'b1;
    cal_req = 1'b1;
    tick();
    cal_req = 1'b0;
    adc_sel = 2'b01;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      adc_cal_busy = {(cyc >= 10 && cyc < 15), cyc[0]};
      st = (cyc <= 4) ? 3'd3 : (cyc <= 10) ? 3'd4 : (cyc <= 15) ? 3'd5 :
           (cyc == 16) ? 3'd6 : 3'd0;
      ev = exp_vec(st, 2'b11, (st == 3'd3) ? 2'b10 : 2'b00, 2'b00);
      checks++;
      if (obs !== ev) begin
        errors++;
        $display("FAIL skip_g10 cycle %0d: got %b expected %b", cyc, obs, ev);
      end
      tick();
    end
  endtask

  task automatic test_no_busy;
    logic [2:0] st;
    logic [11:0] ev;
    do_reset();
    adc_sel = 2'b11;
    cal_req = 1'b1;
    tick();
    cal_req = 1'b0;
    for (int cyc = 1; cyc <= 38; cyc++) begin
      st = (cyc <= 8) ? 3'd1 : (cyc <= 16) ? 3'd2 : (cyc <= 20) ? 3'd3 :
           (cyc <= 36) ? 3'd4 : (cyc == 37) ? 3'd6 : 3'd0;
      ev = exp_vec(st, (st == 3'd1) ? 2'b00 : 2'b11, (st == 3'd3) ? 2'b11 : 2'b00,
                   (cyc >= 37) ? 2'b01 : 2'b00);
      checks++;
      if (obs !== ev) begin
        errors++;
        $display("FAIL no_busy cycle %0d: got %b expected %b", cyc, obs, ev);
      end
      if (cyc < 38) tick();
    end
    adc_sel = 2'b01;
    cal_req = 1'b1;
    tick();
    cal_req = 1'b0;
    checks++;
    if (obs !== exp_vec(3'd1, 2'b10, 2'b00, 2'b00)) begin
      errors++;
      $display("FAIL no_busy_rereq: got %b expected %b", obs, exp_vec(3'd1, 2'b10, 2'b00, 2'b00));
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_stuck_busy;
    logic [2:0] st;
    logic [11:0] ev;
    int dones;
    dones = 0;
    do_reset();
    adc_sel = 2'b11;
    cal_req = 1'b1;
    tick();
    cal_req = 1'b0;
    for (int cyc = 1; cyc <= 88; cyc++) begin
      adc_cal_busy = (cyc >= 22) ? 2'b11 : 2'b00;
      st = (cyc <= 8) ? 3'd1 : (cyc <= 16) ? 3'd2 : (cyc <= 20) ? 3'd3 :
           (cyc <= 22) ? 3'd4 : (cyc <= 86) ? 3'd5 : (cyc == 87) ? 3'd6 : 3'd0;
      ev = exp_vec(st, (st == 3'd1) ? 2'b00 : 2'b11, (st == 3'd3) ? 2'b11 : 2'b00,
                   (cyc >= 87) ? 2'b10 : 2'b00);
      checks++;
      if (obs_to !== ev) begin
        errors++;
        $display("FAIL stuck_busy cycle %0d: got %b expected %b", cyc, obs_to, ev);
      end
      if (cal_done_to) dones++;
      tick();
    end
    checks++;
    if (dones !== 1) begin
      errors++;
      $display("FAIL stuck_busy_done_count: got %0d expected 1", dones);
    end
    adc_cal_busy = 2'b00;
  endtask

  task automatic test_abort;
    logic [2:0] st;
    logic [11:0] ev;
    do_reset();
    adc_sel = 2'b01;
    cal_req = 1'b1;
    tick();
    cal_req = 1'b0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      if (cyc == 3) adc_sel = 2'b10;
      cal_req = (cyc == 5);
      abort = (cyc == 12);
      st = (cyc <= 8) ? 3'd1 : (cyc <= 12) ? 3'd2 : 3'd0;
      ev = exp_vec(st, (st == 3'd1) ? 2'b10 : 2'b11, 2'b00, 2'b00);
      checks++;
      if (obs !== ev) begin
        errors++;
        $display("FAIL abort cycle %0d: got %b expected %b", cyc, obs, ev);
      end
      tick();
    end
    cal_req = 1'b0;
    abort = 1'b0;
    skip_adc_rst = 1'b1;
    adc_sel = 2'b01;
    cal_req = 1'b1;
    tick();
    cal_req = 1'b0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      adc_cal_busy = (cyc >= 5) ? 2'b01 : 2'b00;
      cal_req = (cyc == 7);
      abort = (cyc == 7);
      st = (cyc <= 4) ? 3'd3 : (cyc == 5) ? 3'd4 : (cyc <= 7) ? 3'd5 : 3'd0;
      ev = exp_vec(st, 2'b11, (st == 3'd3) ? 2'b01 : 2'b00, 2'b00);
      checks++;
      if (obs !== ev) begin
        errors++;
        $display("FAIL collision cycle %0d: got %b expected %b", cyc, obs, ev);
      end
      tick();
    end
    adc_cal_busy = 2'b00;
    skip_adc_rst = 1'b0;
  endtask

  task automatic test_async_reset;
    do_reset();
    adc_sel = 2'b11;
    skip_adc_rst = 1'b1;
    cal_req = 1'b1;
    tick();
    cal_req = 1'b0;
    checks++;
    if (obs !== exp_vec(3'd3, 2'b11, 2'b11, 2'b00)) begin
      errors++;
      $display("FAIL async_pre: got %b expected %b", obs, exp_vec(3'd3, 2'b11, 2'b11, 2'b00));
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== exp_vec(3'd0, 2'b11, 2'b00, 2'b00)) begin
      errors++;
      $display("FAIL async_rst: got %b expected %b", obs, exp_vec(3'd0, 2'b11, 2'b00, 2'b00));
    end
    #2;
    rst = 1'b0;
    skip_adc_rst = 1'b0;
    tick();
    adc_sel = 2'b00;
    cal_req = 1'b1;
    tick();
    cal_req = 1'b0;
    checks++;
    if (obs !== exp_vec(3'd0, 2'b11, 2'b00, 2'b00)) begin
      errors++;
      $display("FAIL sel0_req: got %b expected %b", obs, exp_vec(3'd0, 2'b11, 2'b00, 2'b00));
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL sel0_busy: got %b expected 0", busy);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_nominal();
    test_skip_g10();
    test_no_busy();
    test_stuck_busy();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule
